// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with architectural condition-code register (Z,N,C).
// Optional CCR_SHADOW_EN adds a shadow CCR saved on interrupt and restored on RTI.
module ex_mem_stage #(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic               valid_in,
  input  logic [DATA_W-1:0]  alu_result_in,
  input  logic [DATA_W-1:0]  store_data_in,
  input  logic [2:0]         ccr_in,
  input  logic               flag_update_in,
  input  logic               setc_in,
  input  logic               clrc_in,
  input  logic [2:0]         flag_clr_in,
  input  logic [RADDR_W-1:0] rdst_in,
  input  logic               reg_write_in,
  input  logic               mem_read_in,
  input  logic               mem_write_in,
`ifdef CCR_SHADOW_EN
  input  logic               int_save_in,
  input  logic               rti_restore_in,
`endif
  output logic               valid_out,
  output logic [DATA_W-1:0]  alu_result_out,
  output logic [DATA_W-1:0]  store_data_out,
  output logic [RADDR_W-1:0] rdst_out,
  output logic               reg_write_out,
  output logic               mem_read_out,
  output logic               mem_write_out,
  output logic [2:0]         ccr_out
);

  localparam int C_BIT = 2;

  logic       accept;
  logic [2:0] ccr_next;
`ifdef CCR_SHADOW_EN
  logic [2:0] shadow;
`endif

  assign accept = valid_in & ~stall & ~flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_out      <= 1'b0;
      alu_result_out <= '0;
      store_data_out <= '0;
      rdst_out       <= '0;
      reg_write_out  <= 1'b0;
      mem_read_out   <= 1'b0;
      mem_write_out  <= 1'b0;
    end else if (flush) begin
      valid_out      <= 1'b0;
      alu_result_out <= '0;
      store_data_out <= '0;
      rdst_out       <= '0;
      reg_write_out  <= 1'b0;
      mem_read_out   <= 1'b0;
      mem_write_out  <= 1'b0;
    end else if (!stall) begin
      valid_out      <= valid_in;
      alu_result_out <= alu_result_in;
      store_data_out <= store_data_in;
      rdst_out       <= rdst_in;
      reg_write_out  <= reg_write_in & valid_in;
      mem_read_out   <= mem_read_in  & valid_in;
      mem_write_out  <= mem_write_in & valid_in;
    end
  end

  // A taken conditional jump (any flag_clr bit) suppresses the flag update
  // and set/clear-carry entirely; only the selected bits of the current CCR clear.
  always_comb begin
    ccr_next = ccr_out;
    if (accept) begin
      if (|flag_clr_in) begin
        ccr_next = ccr_out & ~flag_clr_in;
      end else begin
        if (flag_update_in) ccr_next = ccr_in;
        if (setc_in && !clrc_in)      ccr_next[C_BIT] = 1'b1;
        else if (clrc_in && !setc_in) ccr_next[C_BIT] = 1'b0;
      end
`ifdef CCR_SHADOW_EN
      if (rti_restore_in) ccr_next = shadow;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ccr_out <= '0;
    else        ccr_out <= ccr_next;
  end

`ifdef CCR_SHADOW_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                                     shadow <= '0;
    else if (accept && int_save_in && !rti_restore_in) shadow <= ccr_out;
  end
`endif

endmodule
